// File: rtl/conv_pkg.sv
// Shared state enum, default kernel, derived widths and result conditioning for conv3x3_stream.
// Latency: none (declarations and a combinational helper only).
// Backpressure: none. Build option CONV_ABS_EN makes sat_u return magnitudes of negative sums.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } conv_state_t;

  localparam int KERNEL_TAPS = 9;

  // Laplacian-style kernel, row-major, index 0 = top-left
  localparam int DEF_KERNEL [0:KERNEL_TAPS-1] = '{1, 1, 1, 1, -8, 1, 1, 1, 1};

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 12;

  // Unsigned pixel zero-extended by one bit, times a signed coefficient
  function automatic int prod_width(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  // Four guard bits cover the nine-term accumulation
  function automatic int sum_width(input int data_w, input int coef_w);
    return prod_width(data_w, coef_w) + 4;
  endfunction

  localparam int PROD_W = prod_width(DEF_DATA_W, DEF_COEF_W);
  localparam int SUM_W  = sum_width(DEF_DATA_W, DEF_COEF_W);

  // Arithmetic shift, then fold or clamp negatives, then clip to the unsigned pixel range
  function automatic logic [31:0] sat_u(input logic signed [63:0] sum, input int shift,
                                        input int data_w);
    logic signed [63:0] v;
    logic signed [63:0] max_v;
    v     = sum >>> shift;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
`ifdef CONV_ABS_EN
    if (v < 64'sd0) v = -v;
`else
    if (v < 64'sd0) v = 64'sd0;
`endif
    if (v > max_v) v = max_v;
    return v[31:0];
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two cascaded one-line delays addressed by column; tap1 = previous line, tap2 = two lines back.
// Latency: taps present the stored pixels for the current column; writes land on the enabled edge.
// Backpressure: none; en freezes both memories and the read-ahead address.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     col,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

  logic [DATA_W-1:0] mem1 [IMG_W];
  logic [DATA_W-1:0] mem2 [IMG_W];
  logic [AW-1:0]     rd_addr;

  // Read one column ahead when a pixel is taken so the synchronous read is ready next time
  always_comb begin
    rd_addr = col;
    if (en) begin
      rd_addr = (col == COL_LAST) ? '0 : col + 1'b1;
    end
  end

  // Registered-read RAM pair; the second line is fed from the first line's tap
  always_ff @(posedge clk) begin
    if (en) begin
      mem1[col] <= din;
      mem2[col] <= tap1;
    end
    tap1 <= mem1[rd_addr];
    tap2 <= mem2[rd_addr];
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream; one output per interior window (CONV_ABS_EN: edge magnitude).
// Latency: 2 register stages (products, then shifted/saturated sum) from accepted pixel to out_valid.
// Backpressure: whole pipeline stalls while out_valid && !out_ready; in_ready drops with it.
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int COEF_W = 12,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_we,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  import conv_pkg::*;

  localparam int P_W = prod_width(DATA_W, COEF_W);
  localparam int S_W = sum_width(DATA_W, COEF_W);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  conv_state_t state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          adv;
  logic          accept;
  logic          last_pix;
  logic          win_ok;

  logic signed [COEF_W-1:0] coef_q [KERNEL_TAPS];

  logic [DATA_W-1:0] lb_tap1;
  logic [DATA_W-1:0] lb_tap2;
  logic [DATA_W-1:0] col_old [3];
  logic [DATA_W-1:0] col_mid [3];
  logic [DATA_W-1:0] col_new [3];
  logic [DATA_W-1:0] win_pix [KERNEL_TAPS];

  logic signed [P_W-1:0] prod_c [KERNEL_TAPS];
  logic signed [P_W-1:0] s1_prod [KERNEL_TAPS];
  logic                  s1_vld;
  logic signed [S_W-1:0] sum_c;

  assign adv      = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and frame-level outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = adv;
        if (in_valid && adv && last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_vld && !out_valid) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == IDLE && start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Kernel registers; out-of-range indices are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_TAPS; i++) coef_q[i] <= COEF_W'(DEF_KERNEL[i]);
    end else if (coef_we) begin
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        if (coef_idx == 4'(i)) coef_q[i] <= coef_data;
      end
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .AW     (CW)
  ) u_lines (
    .clk  (clk),
    .en   (accept),
    .col  (col_q),
    .din  (in_data),
    .tap1 (lb_tap1),
    .tap2 (lb_tap2)
  );

  // Incoming window column, top row first, then the full 3x3 window in kernel order
  always_comb begin
    col_new[0] = lb_tap2;
    col_new[1] = lb_tap1;
    col_new[2] = in_data;
    for (int r = 0; r < 3; r++) begin
      win_pix[r*3+0] = col_old[r];
      win_pix[r*3+1] = col_mid[r];
      win_pix[r*3+2] = col_new[r];
    end
  end

  // Slide the two retained window columns on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        col_old[r] <= col_mid[r];
        col_mid[r] <= col_new[r];
      end
    end
  end

  // Signed products with the pixel zero-extended
  always_comb begin
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      prod_c[i] = P_W'($signed({1'b0, win_pix[i]})) * P_W'(coef_q[i]);
    end
  end

  // Stage 1 valid: only complete interior windows produce a result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s1_vld <= 1'b0;
    else if (adv) s1_vld <= accept && win_ok;
  end

  // Stage 1 product registers
  always_ff @(posedge clk) begin
    if (adv && accept) s1_prod <= prod_c;
  end

  // Nine-term accumulation
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) sum_c = sum_c + S_W'(s1_prod[i]);
  end

  // Stage 2 output register; holds its value while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= s1_vld;
      if (s1_vld) out_data <= DATA_W'(sat_u(64'(sum_c), SHIFT, DATA_W));
    end
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 convolution engine for single-channel pixels; successor to the address-driven RAM-walking convolver.
- Accepts a raster-order pixel stream (valid/ready) and holds two line buffers internally, so each input pixel is read exactly once.
- Runtime-programmable signed kernel, configurable output shift and saturation.
- Emits one filtered pixel per interior window ((IMG_W-2)x(IMG_H-2) per frame) to the downstream writer.

Parameters:
- DATA_W, 8, pixel width (unsigned).
- IMG_W, 512, pixels per line (>=3).
- IMG_H, 512, lines per frame (>=3).
- COEF_W, 12, signed coefficient width.
- SHIFT, 0, arithmetic right shift applied to the sum before saturation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- coef_we  in  1  coefficient write strobe
- coef_idx  in  4  kernel index 0..8, row-major (0 = top-left)
- coef_data  in  COEF_W  signed coefficient
- in_valid  in  1  input pixel valid
- in_ready  out  1  engine accepts pixel
- in_data  in  DATA_W  input pixel
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  saturated result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output accepted

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Column/row counters 0; state IDLE.
  - Kernel = {1,1,1, 1,-8,1, 1,1,1}.
  - Line buffer contents are don't-care.
- State machine:
  - IDLE: in_ready=0. start -> RUN, busy=1, counters cleared.
  - RUN: accept pixels while in_valid&in_ready. Column wraps at IMG_W-1 and increments the row. Accepting pixel (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: in_ready=0; stay until the pipeline and output register are empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start is ignored when not in IDLE.
- Coefficient writes:
  - Accepted in any state; coef_idx>8 is ignored.
  - A write during RUN takes effect on the next accepted pixel. No glitch within a single window computation is required.
- Windowing:
  - Each accepted pixel shifts the 3x3 window: its column gets the two line-buffer taps plus in_data. The line buffers are then updated.
  - A window is valid when row>=2 and col>=2. Its output is centred at (col-1, row-1).
  - No border pixels are produced.
- Pipeline:
  - Stage 1 registers the 9 products, each DATA_W+COEF_W+1 bits signed (pixel zero-extended).
  - Stage 2 registers sum (product width +4), >>>SHIFT, saturate to [0, 2^DATA_W-1].
  - Latency from accepted pixel to out_valid is 2 cycles with out_ready held high.
- Backpressure:
  - in_ready = (state==RUN) and the pipeline can advance.
  - The pipeline advances when the output register is empty or out_ready=1. Stages hold when stalled.
  - No pixel is dropped or duplicated.
- Output handshake: out_data is stable while out_valid=1 and out_ready=0.
- Reset mid-frame: all state aborts immediately, no done pulse. Coefficients return to their defaults.

Optional Feature:
- CONV_ABS_EN defined: negative shifted sums are replaced by their magnitude before upper saturation (edge-magnitude mode).
- Undefined: negative sums clamp to 0.

Decomposition:
- Package conv_pkg holds:
  - State enum (IDLE/RUN/DRAIN/DONE).
  - Default kernel constant array.
  - Derived widths PROD_W and SUM_W.
  - Function sat_u(sum) implementing shift, abs and saturation.
- One sub-module, conv_line_buffer: IMG_W-deep, two-tap shift/RAM line delay with an enable, inferring BRAM.

Test Plan:
- IMG_W=IMG_H=4, default kernel, all pixels 10 -> 4 outputs, each 0 (sum 0); done pulses once after the 4th handshake.
- 4x4 frame, centre-region pixel 100 with other pixels 0, default kernel -> outputs touching it = 100 (neighbour, positive), centred one = 0 (clamped, -800). With CONV_ABS_EN the centred output = 255.
- Load all coefficients 1, SHIFT=3, all pixels 255 -> each output = 255 (2295>>3=286, saturated).
- Random 8x6 image, random out_ready at 30% duty, random in_valid gaps -> output sequence matches a golden model exactly. out_data is stable while stalled.
- Assert rst at the 10th accepted pixel -> all outputs 0 within the same cycle. A following start plus a full frame produces correct results with default coefficients.
- start pulsed during RUN and coef_idx=9 writes -> no effect on counters or outputs.
